pulse_gen: RTL and testbench
============================

// Module: pulse_gen
//
// PURPOSE
// Programmable pulse/strobe generator: the stimulus side of the event counters.
// On a trigger it waits a delay, then emits a train of high pulses with a
// programmed width, gap and count. It drives DUT stimulus lines, or the
// start/stop/count strobes of a counter, with cycle-exact timing.
//
// PARAMETERS
// WIDTH  16  bit width of the delay, width, gap and reps fields and their counters
//
// PORTS
// clk      in   1      system clock, all logic on posedge
// sysrst   in   1      synchronous active-high reset
// delay    in   WIDTH  cycles from trigger to the first pulse
// width    in   WIDTH  high cycles per pulse (0 treated as 1)
// gap      in   WIDTH  low cycles between pulses (0 treated as 1)
// reps     in   WIDTH  number of pulses in the train (0 treated as 1)
// trigger  in   1      start a sequence (level sampled each clk)
// abort    in   1      cancel a running sequence
// pulse    out  1      registered pulse output
// busy     out  1      sequence in progress (DELAY/HIGH/GAP)
// done     out  1      one-cycle strobe after the last pulse completes
// left     out  WIDTH  pulses still to be started, including the current one
//
// BEHAVIOUR
// - All outputs registered. Reset: pulse=0, busy=0, done=0, left=0, state=IDLE.
// - sysrst has priority over everything. Within the same cycle, abort has
//   priority over trigger.
// - FSM states: IDLE, DELAY, HIGH, GAP.
// - IDLE + trigger: latch delay/width/gap/reps into shadow registers, apply the
//   0->1 clamps, set left=reps. Next state is DELAY, or HIGH if delay=0.
//   Input changes while busy have no effect.
// - Timing: trigger sampled in cycle 0. pulse is high in cycles 1+D .. D+W.
//   Between pulses it is low for exactly G cycles. Pulse k (k=0..N-1) starts at
//   cycle 1+D+k*(W+G).
// - busy is high from cycle 1 through the last high cycle of the last pulse.
// - left decrements on the last HIGH cycle of each pulse; it reads 0 once the
//   train ends.
// - done is high for exactly one cycle: the first cycle after the last high
//   cycle. It coincides with busy=0 and state IDLE. A trigger during that done
//   cycle is accepted normally.
// - DELAY counts D cycles, then goes to HIGH.
// - HIGH counts W cycles. Then: GAP if left>1, else IDLE with done.
// - GAP counts G cycles, then goes to HIGH.
// - abort in any non-IDLE state: the next cycle has pulse=0, busy=0, left=0,
//   state IDLE, and no done. abort in IDLE has no effect.
// - Counters are WIDTH bits with no wrap. The maximum total duration is
//   D + N*W + (N-1)*G; overflow of this sum is irrelevant because each phase
//   counts independently.
// - Without the optional feature: trigger while busy is ignored.
//
// CONFIGURATION
// PULSE_GEN_RETRIGGER_EN
// - Defined: trigger while busy (and abort=0) restarts the sequence. It
//   relatches the inputs and behaves exactly as a trigger from IDLE, with cycle 0
//   being the retrigger cycle. pulse drops to 0 in cycle 1 unless D=0. No done
//   strobe for the cut-short train.
// - Undefined: trigger while busy is ignored entirely.
//
// TESTING
// 1. D=3, W=2, N=1, trigger in cycle 0 -> pulse high in cycles 4-5; busy in
//    cycles 1-5; done in cycle 6; left 1->0 at cycle 6.
// 2. D=0, W=1, G=2, N=3 -> pulse high in cycles 1, 4, 7; done in cycle 8;
//    left reads 3,2,1,0.
// 3. W=0, G=0, N=0, D=0 -> clamps give a single 1-cycle pulse in cycle 1 and
//    done in cycle 2.
// 4. D=5, W=4, abort in cycle 7 (in HIGH) -> pulse=0, busy=0 from cycle 8;
//    done never asserted. trigger+abort in the same cycle from IDLE -> stays
//    IDLE.
// 5. sysrst asserted mid-GAP -> next cycle all outputs 0 and IDLE. Change the
//    inputs while busy -> the train is unaffected.
// 6. Retrigger (D=2, W=3): second trigger in cycle 4. Without
//    PULSE_GEN_RETRIGGER_EN -> ignored, done in cycle 6. With it -> pulse low in
//    cycles 5-6, high in cycles 7-9, single done in cycle 10.

Source files
------------

// File: rtl/pulse_gen_if.sv
// Control/status bundle for pulse_gen: programmed timing fields and trigger/abort in,
// pulse train and status out.
interface pulse_gen_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] delay;
    logic [WIDTH-1:0] width;
    logic [WIDTH-1:0] gap;
    logic [WIDTH-1:0] reps;
    logic             trigger;
    logic             abort;
    logic             pulse;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] left;

    modport master (
        output delay, width, gap, reps, trigger, abort,
        input  pulse, busy, done, left
    );

    modport slave (
        input  delay, width, gap, reps, trigger, abort,
        output pulse, busy, done, left
    );
endinterface

// File: rtl/pulse_gen.sv
// Programmable pulse train generator: delay, then reps pulses of width high / gap low.
// Optional PULSE_GEN_RETRIGGER_EN lets a trigger restart a running sequence.
module pulse_gen #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        sysrst,
    pulse_gen_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} state_t;

`ifdef PULSE_GEN_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] left_q, left_n;
    logic [WIDTH-1:0] w_q, w_n;
    logic [WIDTH-1:0] g_q, g_n;
    logic             pulse_q, busy_q, done_q, done_n;

    logic [WIDTH-1:0] w_in, g_in, reps_in;
    logic             active, start;

    // Zero-length width/gap/reps would stall the counters, so they run as one.
    assign w_in    = (bus.width == '0) ? ONE : bus.width;
    assign g_in    = (bus.gap   == '0) ? ONE : bus.gap;
    assign reps_in = (bus.reps  == '0) ? ONE : bus.reps;

    assign active  = (state != IDLE);
    assign start   = bus.trigger && !bus.abort && (!active || RETRIG);

    // Each counter holds "cycles remaining minus one" for the current phase.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n = state;
        cnt_n   = cnt;
        left_n  = left_q;
        w_n     = w_q;
        g_n     = g_q;
        done_n  = 1'b0;

        if (active && bus.abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            left_n  = '0;
        end else if (start) begin
            w_n    = w_in;
            g_n    = g_in;
            left_n = reps_in;
            if (bus.delay == '0) begin
                state_n = HIGH;
                cnt_n   = w_in - ONE;
            end else begin
                state_n = DELAY;
                cnt_n   = bus.delay - ONE;
            end
        end else begin
            unique case (state)
                DELAY, GAP: begin
                    if (cnt == '0) begin
                        state_n = HIGH;
                        cnt_n   = w_q - ONE;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        left_n = left_q - ONE;
                        if (left_q > ONE) begin
                            state_n = GAP;
                            cnt_n   = g_q - ONE;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (sysrst) begin
            state   <= IDLE;
            cnt     <= '0;
            left_q  <= '0;
            w_q     <= '0;
            g_q     <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            left_q  <= left_n;
            w_q     <= w_n;
            g_q     <= g_n;
            pulse_q <= (state_n == HIGH);
            busy_q  <= (state_n != IDLE);
            done_q  <= done_n;
        end
    end

    assign bus.pulse = pulse_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.left  = left_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen; traces pulse/busy/done per cycle after
// the trigger and compares them with hand-derived bit masks (bit k = cycle k).
module tb_pulse_gen;

    localparam int WIDTH = 16;
    localparam int NCYC  = 20;

    logic clk = 1'b0;
    logic sysrst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] p_tr, b_tr, d_tr;
    logic [WIDTH-1:0] left_tr [0:31];

    pulse_gen_if #(.WIDTH(WIDTH)) bus ();

    pulse_gen #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .sysrst (sysrst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Trigger in cycle 0, then record outputs for cycles 1..NCYC.
    // *_at arguments name the cycle in which that event is driven (-1 = never).
    task automatic run(input int d, input int w, input int g, input int n,
                       input int abort_at, input int rst_at, input int chg_at, input int trig_at);
        bus.delay   = WIDTH'(d);
        bus.width   = WIDTH'(w);
        bus.gap     = WIDTH'(g);
        bus.reps    = WIDTH'(n);
        bus.trigger = 1'b1;
        bus.abort   = (abort_at == 0);
        p_tr = '0;
        b_tr = '0;
        d_tr = '0;
        for (int i = 1; i <= NCYC; i++) begin
            @(posedge clk);
            #1;
            p_tr[i]    = bus.pulse;
            b_tr[i]    = bus.busy;
            d_tr[i]    = bus.done;
            left_tr[i] = bus.left;
            bus.trigger = (i == trig_at);
            bus.abort   = (i == abort_at);
            sysrst      = (i == rst_at);
            if (i == chg_at) begin
                bus.delay = 16'd7;
                bus.width = 16'd7;
                bus.gap   = 16'd7;
                bus.reps  = 16'd7;
            end
        end
        bus.trigger = 1'b0;
        bus.abort   = 1'b0;
        sysrst      = 1'b0;
    endtask

    initial begin
        sysrst      = 1'b1;
        bus.delay   = '0;
        bus.width   = '0;
        bus.gap     = '0;
        bus.reps    = '0;
        bus.trigger = 1'b1;
        bus.abort   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pulse", 32'(bus.pulse), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_left",  32'(bus.left),  32'd0);
        sysrst      = 1'b0;
        bus.trigger = 1'b0;
        @(posedge clk);
        #1;

        // 1: D=3 W=2 N=1
        run(3, 2, 1, 1, -1, -1, -1, -1);
        check("t1_pulse", p_tr, 32'h0000_0030);
        check("t1_busy",  b_tr, 32'h0000_003E);
        check("t1_done",  d_tr, 32'h0000_0040);
        check("t1_left5", 32'(left_tr[5]), 32'd1);
        check("t1_left6", 32'(left_tr[6]), 32'd0);

        // 2: D=0 W=1 G=2 N=3
        run(0, 1, 2, 3, -1, -1, -1, -1);
        check("t2_pulse", p_tr, 32'h0000_0092);
        check("t2_busy",  b_tr, 32'h0000_00FE);
        check("t2_done",  d_tr, 32'h0000_0100);
        check("t2_left1", 32'(left_tr[1]), 32'd3);
        check("t2_left4", 32'(left_tr[4]), 32'd2);
        check("t2_left7", 32'(left_tr[7]), 32'd1);
        check("t2_left8", 32'(left_tr[8]), 32'd0);

        // 3: all-zero fields clamp to a single one-cycle pulse
        run(0, 0, 0, 0, -1, -1, -1, -1);
        check("t3_pulse", p_tr, 32'h0000_0002);
        check("t3_busy",  b_tr, 32'h0000_0002);
        check("t3_done",  d_tr, 32'h0000_0004);
        check("t3_left1", 32'(left_tr[1]), 32'd1);

        // 4a: abort in cycle 7 while HIGH
        run(5, 4, 1, 1, 7, -1, -1, -1);
        check("t4_pulse", p_tr, 32'h0000_00C0);
        check("t4_busy",  b_tr, 32'h0000_00FE);
        check("t4_done",  d_tr, 32'h0000_0000);
        check("t4_left8", 32'(left_tr[8]), 32'd0);

        // 4b: trigger and abort together from IDLE
        run(0, 2, 1, 1, 0, -1, -1, -1);
        check("t4b_pulse", p_tr, 32'h0000_0000);
        check("t4b_busy",  b_tr, 32'h0000_0000);

        // 5a: sysrst in cycle 4 (mid-GAP)
        run(0, 2, 4, 3, -1, 4, -1, -1);
        check("t5_pulse", p_tr, 32'h0000_0006);
        check("t5_busy",  b_tr, 32'h0000_001E);
        check("t5_done",  d_tr, 32'h0000_0000);
        check("t5_left5", 32'(left_tr[5]), 32'd0);

        // 5b: inputs changed while busy do not disturb the train
        run(0, 1, 2, 3, -1, -1, 2, -1);
        check("t5b_pulse", p_tr, 32'h0000_0092);
        check("t5b_done",  d_tr, 32'h0000_0100);
        bus.delay = '0; bus.width = '0; bus.gap = '0; bus.reps = '0;

        // Trigger during the done cycle is accepted
        run(0, 1, 1, 1, -1, -1, -1, 2);
        check("tdone_pulse", p_tr, 32'h0000_000A);
        check("tdone_done",  d_tr, 32'h0000_0014);

        // 6: second trigger in cycle 4 while HIGH
        run(2, 3, 1, 1, -1, -1, -1, 4);
`ifdef PULSE_GEN_RETRIGGER_EN
        check("t6_pulse", p_tr, 32'h0000_0398);
        check("t6_busy",  b_tr, 32'h0000_03FE);
        check("t6_done",  d_tr, 32'h0000_0400);
`else
        check("t6_pulse", p_tr, 32'h0000_0038);
        check("t6_busy",  b_tr, 32'h0000_003E);
        check("t6_done",  d_tr, 32'h0000_0040);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
